// File: rtl/soc_io_pkg.sv
// Shared definitions for the soc_io subsystem: register offsets above the GPIO block,
// UART FSM states and the byte-lane merge helper.
package soc_io_pkg;

    // Offsets are added to NUM_GPIO to form the word address
    localparam int unsigned UART_OFS    = 0;
    localparam int unsigned TMR_CNT_OFS = 1;
    localparam int unsigned TMR_CMP_OFS = 2;
    localparam int unsigned IRQ_OFS     = 3;

    typedef enum logic [1:0] {
        UartIdle,
        UartStart,
        UartData,
        UartStop
    } uart_state_e;

    function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  wmask);
        logic [31:0] m;
        m = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
        return (old_val & ~m) | (new_val & m);
    endfunction

endpackage

// File: rtl/soc_io_uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit, CLK_DIV clocks each.
module uart_tx_8n1
    import soc_io_pkg::*;
#(
    parameter int unsigned CLK_DIV = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    uart_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UartIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        last    = (cnt_q == CntW'(CLK_DIV - 1));

        unique case (state_q)
            UartIdle: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = UartStart;
                    cnt_d   = '0;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            UartStart: begin
                if (last) begin
                    state_d = UartData;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UartData: begin
                if (last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = UartStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UartStop: begin
                if (last) begin
                    cnt_d = '0;
                    // A start on the final stop cycle chains frames with no idle gap
                    if (start) begin
                        state_d = UartStart;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = UartIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = UartIdle;
        endcase
    end

    assign busy = (state_q != UartIdle);
    assign tx   = tx_q;

endmodule

// File: rtl/soc_io.sv
// Memory-mapped IO subsystem: address decode, byte-masked GPIO registers, 8N1 UART,
// free-running timer with sticky compare interrupt, and registered readback.
module soc_io
    import soc_io_pkg::*;
#(
    parameter int unsigned NUM_GPIO = 2,
    parameter int unsigned GPIO_W   = 8,
    parameter int unsigned CLK_DIV  = 234,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         io_sel,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [31:0]                  wdata,
    input  logic [3:0]                   wmask,
    input  logic                         rstrb,
    output logic [31:0]                  rdata,
    output logic                         rvalid,
    output logic [NUM_GPIO*GPIO_W-1:0]   gpio_out,
    output logic                         uart_tx,
    output logic                         irq
);

    localparam logic [ADDR_W-1:0] UartAddr   = ADDR_W'(NUM_GPIO + UART_OFS);
    localparam logic [ADDR_W-1:0] TmrCntAddr = ADDR_W'(NUM_GPIO + TMR_CNT_OFS);
    localparam logic [ADDR_W-1:0] TmrCmpAddr = ADDR_W'(NUM_GPIO + TMR_CMP_OFS);
    localparam logic [ADDR_W-1:0] IrqAddr    = ADDR_W'(NUM_GPIO + IRQ_OFS);

    logic [GPIO_W-1:0] gpio_q [NUM_GPIO];
    logic [GPIO_W-1:0] gpio_d [NUM_GPIO];
    logic [31:0]       tmr_cnt_q, tmr_cnt_d;
    logic [31:0]       tmr_cmp_q, tmr_cmp_d;
    logic              match_q, match_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic        wr_en, rd_en;
    logic        uart_start, uart_busy;
    logic [31:0] rd_word;

    assign wr_en      = io_sel && (wmask != 4'b0000);
    assign rd_en      = io_sel && rstrb;
    assign uart_start = wr_en && (addr == UartAddr) && wmask[0];

    uart_tx_8n1 #(
        .CLK_DIV (CLK_DIV)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .start (uart_start),
        .data  (wdata[7:0]),
        .busy  (uart_busy),
        .tx    (uart_tx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                gpio_q[i] <= '0;
            end
            tmr_cnt_q <= '0;
            tmr_cmp_q <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                gpio_q[i] <= gpio_d[i];
            end
            tmr_cnt_q <= tmr_cnt_d;
            tmr_cmp_q <= tmr_cmp_d;
            match_q   <= match_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_GPIO; i++) begin
            gpio_d[i] = gpio_q[i];
            if (wr_en && (addr == ADDR_W'(i))) begin
                gpio_d[i] = GPIO_W'(apply_wmask(32'(gpio_q[i]), wdata, wmask));
            end
        end

        // CPU write overrides the increment only on the enabled byte lanes
        tmr_cnt_d = tmr_cnt_q + 32'd1;
        if (wr_en && (addr == TmrCntAddr)) begin
            tmr_cnt_d = apply_wmask(tmr_cnt_d, wdata, wmask);
        end

        tmr_cmp_d = tmr_cmp_q;
        if (wr_en && (addr == TmrCmpAddr)) begin
            tmr_cmp_d = apply_wmask(tmr_cmp_q, wdata, wmask);
        end

        match_d = match_q;
        if (wr_en && (addr == IrqAddr) && wmask[0] && wdata[0]) begin
            match_d = 1'b0;
        end
        if (tmr_cnt_q == tmr_cmp_q) begin
            match_d = 1'b1;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_word = 32'(gpio_q[i]);
            end
        end
        if (addr == UartAddr) begin
            rd_word = {31'b0, uart_busy};
        end else if (addr == TmrCntAddr) begin
            rd_word = tmr_cnt_q;
        end else if (addr == TmrCmpAddr) begin
            rd_word = tmr_cmp_q;
        end else if (addr == IrqAddr) begin
            rd_word = {31'b0, match_q};
        end

        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (rd_en) begin
            rdata_d  = rd_word;
            rvalid_d = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_gpio_out
        assign gpio_out[g*GPIO_W +: GPIO_W] = gpio_q[g];
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign irq    = match_q;

endmodule
